// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner
// Brief   : Column-strobed ROWS x COLS keypad scanner with synchroniser,
//           press/release debounce, multi-key rejection and valid/ready output.
// Revision: 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV        = 4,
  localparam int CODE_W         = ((ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   rows,
  output logic [COLS-1:0]   col_drive,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              key_held,
  output logic              multi_key
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] c_DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] c_DB_TARGET  = BW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_COL_LAST   = CW'(COLS - 1);

  typedef enum logic [1:0] {
    S_SCAN       = 2'd0,
    S_PRESS_DB   = 2'd1,
    S_HELD       = 2'd2,
    S_RELEASE_DB = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ROWS-1:0]   r_sync;
  logic [ROWS-1:0]   r_rs;
  logic [DW-1:0]     r_dwell;
  logic [BW-1:0]     r_db_cnt;
  logic [COLS-1:0]   r_col_drive;
  logic [CW-1:0]     r_col_idx;
  logic [ROWS-1:0]   r_row_oh;
  logic [RW-1:0]     r_row_idx;
  logic              r_key_valid;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_held;
  logic              r_multi;

  logic              w_rs_zero;
  logic              w_rs_onehot;
  logic [RW-1:0]     w_row_enc;
  logic              w_dwell_last;
  logic [BW-1:0]     w_db_next;
  logic              w_db_done;
  logic [CODE_W-1:0] w_code;

  logic w_rotate;
  logic w_capture;
  logic w_db_clr;
  logic w_db_inc;
  logic w_emit;
  logic w_release;
  logic w_multi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_rs   <= '0;
    end else begin
      r_sync <= rows;
      r_rs   <= r_sync;
    end
  end

  assign w_rs_zero    = (r_rs == '0);
  assign w_rs_onehot  = !w_rs_zero && ((r_rs & (r_rs - 1'b1)) == '0);
  assign w_dwell_last = (r_dwell == c_DWELL_LAST);
  // Saturates so a stalled press holds at the target count.
  assign w_db_next    = (r_db_cnt == c_DB_TARGET) ? c_DB_TARGET : r_db_cnt + BW'(1);
  assign w_db_done    = (w_db_next == c_DB_TARGET);
  assign w_code       = CODE_W'(r_row_idx) * CODE_W'(COLS) + CODE_W'(r_col_idx);

  always_comb begin
    w_row_enc = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r_rs[i]) w_row_enc = RW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_SCAN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rotate     = 1'b0;
    w_capture    = 1'b0;
    w_db_clr     = 1'b0;
    w_db_inc     = 1'b0;
    w_emit       = 1'b0;
    w_release    = 1'b0;
    w_multi      = 1'b0;
    case (r_state)
      S_SCAN: begin
        if (w_dwell_last) begin
          if (w_rs_zero) begin
            w_rotate = 1'b1;
          end else if (w_rs_onehot) begin
            w_capture    = 1'b1;
            w_db_clr     = 1'b1;
            w_state_next = S_PRESS_DB;
          end else begin
            w_multi  = 1'b1;
            w_rotate = 1'b1;
          end
        end
      end
      S_PRESS_DB: begin
        if (r_rs == r_row_oh) begin
          if (w_db_done && !r_key_valid) begin
            w_emit       = 1'b1;
            w_state_next = S_HELD;
          end else begin
            w_db_inc = 1'b1;
          end
        end else begin
          w_db_clr     = 1'b1;
          w_rotate     = 1'b1;
          w_state_next = S_SCAN;
        end
      end
      S_HELD: begin
        if (w_rs_zero) begin
          w_db_clr     = 1'b1;
          w_state_next = S_RELEASE_DB;
        end
      end
      S_RELEASE_DB: begin
        if (!w_rs_zero) begin
          w_state_next = S_HELD;
        end else if (w_db_done) begin
          w_release    = 1'b1;
          w_rotate     = 1'b1;
          w_state_next = S_SCAN;
        end else begin
          w_db_inc = 1'b1;
        end
      end
      default: w_state_next = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dwell     <= '0;
      r_db_cnt    <= '0;
      r_col_drive <= COLS'(1);
      r_col_idx   <= '0;
      r_row_oh    <= '0;
      r_row_idx   <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_held  <= 1'b0;
      r_multi     <= 1'b0;
    end else begin
      if (r_state == S_SCAN) r_dwell <= w_dwell_last ? '0 : r_dwell + DW'(1);
      else                   r_dwell <= '0;

      if (w_db_clr)      r_db_cnt <= '0;
      else if (w_db_inc) r_db_cnt <= w_db_next;

      if (w_rotate) begin
        r_col_drive <= {r_col_drive[COLS-2:0], r_col_drive[COLS-1]};
        r_col_idx   <= (r_col_idx == c_COL_LAST) ? '0 : r_col_idx + CW'(1);
      end

      if (w_capture) begin
        r_row_oh  <= r_rs;
        r_row_idx <= w_row_enc;
      end

      if (w_emit) begin
        r_key_code  <= w_code;
        r_key_valid <= 1'b1;
      end else if (r_key_valid && key_ready) begin
        r_key_valid <= 1'b0;
      end

      if (w_emit)         r_key_held <= 1'b1;
      else if (w_release) r_key_held <= 1'b0;

      r_multi <= w_multi;
    end
  end

  assign col_drive = r_col_drive;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;
  assign multi_key = r_multi;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scanned matrix-keypad controller: actively strobes one column at a time and samples the row lines. It synchronises and debounces each keypress, then delivers one key code per press on a valid/ready interface. It generalises the team's combinational 3x4 keypad decoder to a parametrised ROWS x COLS matrix with debounce, release detection, multi-key rejection and flow control. It sits between the keypad pins and the digit-consuming logic.

## Interface
- ROWS, 4, number of row inputs (≥1)
- COLS, 3, number of column strobes (≥2)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required for press and release (≥1)
- SCAN_DIV, 4, clock cycles each column is driven per scan step (≥3)
- CODE_W (derived, localparam) = clog2(ROWS*COLS), minimum 1; 4 with defaults
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- rows  input  ROWS  raw row lines from the keypad, active-high, asynchronous to clk
- col_drive  output  COLS  one-hot active-high column strobe
- key_valid  output  1  key event available
- key_code  output  CODE_W  row*COLS + col of the event; stable while key_valid
- key_ready  input  1  consumer accepts event when high with key_valid
- key_held  output  1  high while a debounced key is pressed
- multi_key  output  1  one-cycle pulse when a scan sample shows >1 row high

## Operation
- rows pass through a 2-flop synchroniser (rs); all decisions use rs.
- Reset values: col_drive = 1 (column 0), key_valid 0, key_code 0, key_held 0, multi_key 0, FSM in SCAN, counters 0.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN: dwell counter runs 0..SCAN_DIV-1 on the current column. On the last dwell cycle, rs is sampled:
  - rs == 0: col_drive rotates to the next column; COLS-1 wraps to 0.
  - Exactly one bit r set: capture row r and column c, freeze col_drive, clear debounce counter, go to PRESS_DB.
  - More than one bit set: pulse multi_key, rotate column, no event.
- PRESS_DB: col_drive is held. Each cycle, rs == captured one-hot increments the counter; any mismatch returns to SCAN with the counter cleared and the column rotated. When the counter reaches DEBOUNCE_CYCLES, go to HELD.
  - On the same edge: key_code <= r*COLS+c, key_valid <= 1, key_held <= 1.
- HELD: col_drive is still frozen. rs == 0 enters RELEASE_DB with the counter cleared. Any other rs value keeps HELD.
- RELEASE_DB: rs == 0 increments the counter; any nonzero rs returns to HELD. When the counter reaches DEBOUNCE_CYCLES, key_held <= 0, the column rotates, and the FSM goes to SCAN.
- Handshake, independent of FSM state:
  - key_valid falls on the edge where key_valid & key_ready.
  - key_code holds its value until the next event.
  - A new event cannot be produced while key_valid is high: PRESS_DB completion stalls, holding at count DEBOUNCE_CYCLES, until key_valid is low.
  - No event is ever dropped or duplicated.
- Auto-repeat is not supported: exactly one event per debounced press.

## Timing
- Synchroniser latency: 2 cycles from a pin edge to rs.
- Worst-case scan-detect latency: COLS*SCAN_DIV cycles plus 2.
- Press latency: from the sample cycle in SCAN, key_valid asserts DEBOUNCE_CYCLES cycles later, given stable rows and key_valid low.
- key_ready high in the cycle key_valid first asserts completes the transfer in that cycle; key_valid is low the next cycle.
- key_ready is ignored while key_valid is low.
- Reset asserted mid-operation immediately forces all reset values, including dropping an untransferred event. After deassertion, scanning restarts at column 0.
- A bounce that shortens the stable run restarts debounce from SCAN with no partial credit.

## Test plan
- Defaults; hold rows=4'b0001 while col_drive=3'b010 (row0, col1) -> exactly one event, key_code=1, key_valid held until key_ready; key_held falls 16 cycles after rs goes to 0.
- Press row3/col2, key_ready tied high -> key_code=11, key_valid high exactly 1 cycle; second event only after release plus a new press.
- Toggle row0 every 5 cycles on col0 for 100 cycles, then hold -> no event during bounce; one event key_code=0 after 16 stable cycles.
- rows=4'b0011 on col1 -> multi_key pulses once per scan of col1, key_valid stays 0, column keeps rotating.
- Leave event 5 unacknowledged, release, press key 7 -> key_code stays 5; after the ready pulse, key_code=7 is delivered.
- Assert reset during PRESS_DB and again with key_valid high -> all outputs return to reset values next edge, col_drive=3'b001.
